// File: rtl/key_debouncer_pkg.sv
// Shared constants, FSM state encoding and helpers for the push-button debouncer.
package key_debouncer_pkg;

  localparam int unsigned KEY_NKEYS_DEFAULT       = 4;
  localparam int unsigned KEY_DEBOUNCE_10MS_50MHZ = 500000;
  localparam int unsigned KEY_DEBOUNCE_SIM        = 8;

  typedef enum logic {
    ST_STABLE = 1'b0,
    ST_COUNT  = 1'b1
  } key_state_e;

  // Pad level seen while a key is not pressed.
  function automatic logic release_level(input bit active_low);
    return active_low;
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-FF synchronizer, stability counter and STABLE/COUNT FSM.
// Drives the committed level and a combinational commit strobe.
module key_debounce_cell
  import key_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_10MS_50MHZ,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic CLK,
  input  logic RESET,
  input  logic key_raw,
  output logic key,
  output logic commit_c
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES >= 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic REL_LEVEL = release_level(ACTIVE_LOW);

  logic             s1;
  logic             s2;
  logic             lvl;
  key_state_e       state;
  key_state_e       state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             key_next;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      s1    <= REL_LEVEL;
      s2    <= REL_LEVEL;
      state <= ST_STABLE;
      cnt   <= '0;
      key   <= 1'b0;
    end else begin
      s1    <= key_raw;
      s2    <= s1;
      state <= state_next;
      cnt   <= cnt_next;
      key   <= key_next;
    end
  end

  assign lvl = s2 ^ ACTIVE_LOW;

  // A new level must differ from the committed one for DEBOUNCE_CYCLES samples in a row.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    key_next   = key;
    commit_c   = 1'b0;
    case (state)
      ST_STABLE: begin
        if (lvl != key) begin
          state_next = ST_COUNT;
          cnt_next   = CNT_W'(1);
        end
      end
      ST_COUNT: begin
        if (lvl == key) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
        end else if (cnt == CNT_LAST) begin
          state_next = ST_STABLE;
          cnt_next   = '0;
          key_next   = lvl;
          commit_c   = 1'b1;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/key_debouncer.sv
// Debounces NKEYS raw push-buttons into a glitch-free KEY vector with a change pulse.
// Define KEY_DEBOUNCER_PRESS_EN to generate per-key press pulses on PRESS.
module key_debouncer
  import key_debouncer_pkg::*;
#(
  parameter int unsigned NKEYS           = KEY_NKEYS_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DEBOUNCE_10MS_50MHZ,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [NKEYS-1:0] KEY_RAW,
  output logic [NKEYS-1:0] KEY,
  output logic             KEY_CHG,
  output logic [NKEYS-1:0] PRESS
);

  if (DEBOUNCE_CYCLES < 2) begin : g_param_check
    $error("key_debouncer: DEBOUNCE_CYCLES must be >= 2");
  end

  logic [NKEYS-1:0] commit_c;

  for (genvar g = 0; g < NKEYS; g++) begin : g_cell
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_cell (
      .CLK     (CLK),
      .RESET   (RESET),
      .key_raw (KEY_RAW[g]),
      .key     (KEY[g]),
      .commit_c(commit_c[g])
    );
  end

  // Simultaneous commits collapse into a single change pulse.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      KEY_CHG <= 1'b0;
    end else begin
      KEY_CHG <= |commit_c;
    end
  end

`ifdef KEY_DEBOUNCER_PRESS_EN
  logic [NKEYS-1:0] press_c;

  // A commit on a key currently at 0 is a 0->1 transition.
  assign press_c = commit_c & ~KEY;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      PRESS <= '0;
    end else begin
      PRESS <= press_c;
    end
  end
`else
  assign PRESS = '0;
`endif

endmodule

// File: tb/tb_key_debouncer.sv
// Self-checking bench for key_debouncer: directed scenarios plus random bouncing,
// compared every cycle against a run-length reference model.
module tb_key_debouncer;
  import key_debouncer_pkg::*;

  localparam int unsigned NK = 4;
  localparam int unsigned D  = KEY_DEBOUNCE_SIM;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [NK-1:0] KEY_RAW;
  logic [NK-1:0] KEY;
  logic          KEY_CHG;
  logic [NK-1:0] PRESS;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: pad delayed two samples; a key flips once its level
  // has disagreed with the committed value for D consecutive samples.
  logic [NK-1:0] h1, h2;
  logic [NK-1:0] m_key, m_press;
  logic          m_chg;
  int            m_run[NK];

  key_debouncer #(
    .NKEYS          (NK),
    .DEBOUNCE_CYCLES(D),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .CLK    (CLK),
    .RESET  (RESET),
    .KEY_RAW(KEY_RAW),
    .KEY    (KEY),
    .KEY_CHG(KEY_CHG),
    .PRESS  (PRESS)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_step();
    logic [NK-1:0] s, commit;
    if (RESET) begin
      h1 = '1; h2 = '1; m_key = '0; m_chg = 1'b0; m_press = '0;
      for (int i = 0; i < NK; i++) m_run[i] = 0;
    end else begin
      s      = ~h2;
      commit = '0;
      for (int i = 0; i < NK; i++) begin
        if (s[i] != m_key[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(D)) begin
            commit[i] = 1'b1;
            m_run[i]  = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_chg = |commit;
`ifdef KEY_DEBOUNCER_PRESS_EN
      m_press = commit & s;
`else
      m_press = '0;
`endif
      m_key = m_key ^ commit;
      h2 = h1;
      h1 = KEY_RAW;
    end
  endtask

  // One clock: sample just after the edge, advance the model, compare.
  task automatic cycle();
    @(posedge CLK);
    #1;
    model_step();
    chk("key", 32'(KEY), 32'(m_key));
    chk("key_chg", 32'(KEY_CHG), 32'(m_chg));
    chk("press", 32'(PRESS), 32'(m_press));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Cycles until KEY[bit] reaches val; returns -1 when the budget expires.
  task automatic wait_key(input int b, input logic val, output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (KEY[b] === val) begin
        n = i;
        break;
      end
    end
  endtask

  int n;
  int pulses;
  int press_hits;
  int bpat[5] = '{0, 1, 0, 0, 1};

  initial begin
    RESET   = 1'b1;
    KEY_RAW = 4'hF;
    run(3);
    chk("reset_key", 32'(KEY), 32'h0);
    chk("reset_chg", 32'(KEY_CHG), 32'h0);
    RESET = 1'b0;

    // 1: idle after reset
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      cycle();
      if (KEY !== 4'h0 || KEY_CHG !== 1'b0) pulses++;
    end
    chk("t1_idle", 32'(pulses), 32'h0);

    // 2: clean press of key 0
    KEY_RAW = 4'hE;
    wait_key(0, 1'b1, n);
    chk("t2_latency", 32'(n), 32'd10);
    chk("t2_key", 32'(KEY), 32'h1);
    chk("t2_chg_hi", 32'(KEY_CHG), 32'h1);
    cycle();
    chk("t2_chg_lo", 32'(KEY_CHG), 32'h0);

    // 3: narrow pulse rejected, then bounce followed by steady press
    KEY_RAW = 4'hC;
    run(7);
    KEY_RAW = 4'hE;
    run(15);
    chk("t3_narrow", 32'(KEY), 32'h1);
    foreach (bpat[j]) begin
      KEY_RAW[1] = 1'(bpat[j]);
      cycle();
    end
    KEY_RAW[1] = 1'b0;
    wait_key(1, 1'b1, n);
    chk("t3_bounce_latency", 32'(n), 32'd10);
    chk("t3_key", 32'(KEY), 32'h3);

    // 4: simultaneous change on several keys
    KEY_RAW = 4'hF;
    run(15);
    chk("t4_released", 32'(KEY), 32'h0);
    KEY_RAW = 4'h6;
    pulses = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (KEY_CHG === 1'b1) pulses++;
    end
    chk("t4_pulses", 32'(pulses), 32'd1);
    chk("t4_key", 32'(KEY), 32'h9);

    // 5: reset mid-count with key held
    KEY_RAW = 4'hF;
    run(15);
    KEY_RAW = 4'hB;
    run(7);
    RESET = 1'b1;
    cycle();
    chk("t5_key_in_reset", 32'(KEY), 32'h0);
    RESET = 1'b0;
    wait_key(2, 1'b1, n);
    chk("t5_relatency", 32'(n), 32'd10);
    chk("t5_key", 32'(KEY), 32'h4);

    // 6: press pulses on key 3
    KEY_RAW = 4'hF;
    run(15);
    press_hits = 0;
    KEY_RAW = 4'h7;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (PRESS !== 4'h0) press_hits += (PRESS === 4'h8) ? 1 : 100;
    end
    KEY_RAW = 4'hF;
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (PRESS !== 4'h0) press_hits += 100;
    end
`ifdef KEY_DEBOUNCER_PRESS_EN
    chk("t6_press", 32'(press_hits), 32'd1);
`else
    chk("t6_press", 32'(press_hits), 32'd0);
`endif

    // Random bouncing against the model, with one reset pulse
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 11) == 0) KEY_RAW = 4'($urandom);
      else if ($urandom_range(0, 5) == 0) KEY_RAW ^= 4'(1 << $urandom_range(0, 3));
      RESET = (i == 300);
      cycle();
    end
    RESET = 1'b0;
    run(20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
